// File: rtl/osram_drain.sv
// Dual-banked output-vector buffer: captures a full set of rows in one cycle, drains one row per handshake.
// Latency: drain_valid_o rises the cycle after a capture into the bank being drained; one row per cycle thereafter.
// Backpressure: drain holds row/index while drain_ready_i is low; capture_ready_o drops while the capture bank is full.
`ifndef NUM_PES
`define NUM_PES 4
`endif

module osram_drain #(
  parameter int NUM_ROWS = `NUM_PES,
  parameter int ROW_W    = 256,
  localparam int IDX_W   = $clog2(NUM_ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_valid_i,
  output logic             capture_ready_o,
  input  logic [ROW_W-1:0] capture_data_i [NUM_ROWS],
  output logic             drain_valid_o,
  input  logic             drain_ready_i,
  output logic [ROW_W-1:0] drain_data_o,
  output logic [IDX_W-1:0] drain_idx_o,
  output logic             drain_last_o,
  output logic [1:0]       bank_full_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROWS - 1);

  // Row storage is never reset: contents only matter once a full flag is set.
  logic [ROW_W-1:0] bank0_q [NUM_ROWS];
  logic [ROW_W-1:0] bank1_q [NUM_ROWS];

  // Full flags indexed by bank number: bit 1 = bank1, bit 0 = bank0.
  logic [1:0]       full_q,     full_d;
  logic             cap_bank_q, cap_bank_d;
  logic             drn_bank_q, drn_bank_d;
  logic [IDX_W-1:0] rd_idx_q,   rd_idx_d;

  logic cap_fire;
  logic drn_fire;
  logic at_last;

  // Readiness and row selection come straight from the registered state, so a
  // bank whose last row drains this cycle still looks full to the capture side.
  assign capture_ready_o = ~full_q[cap_bank_q];
  assign drain_valid_o   = full_q[drn_bank_q];
  assign at_last         = (rd_idx_q == LAST_IDX);
  assign drain_last_o    = drain_valid_o && at_last;
  assign drain_idx_o     = rd_idx_q;
  assign drain_data_o    = drn_bank_q ? bank1_q[rd_idx_q] : bank0_q[rd_idx_q];
  assign bank_full_o     = full_q;

  assign cap_fire = capture_valid_i && capture_ready_o;
  assign drn_fire = drain_valid_o && drain_ready_i;

  // Next-state for flags and pointers; capture and drain always touch different
  // banks when both fire, so their flag updates never collide.
  always_comb begin
    full_d     = full_q;
    cap_bank_d = cap_bank_q;
    drn_bank_d = drn_bank_q;
    rd_idx_d   = rd_idx_q;
    if (cap_fire) begin
      full_d[cap_bank_q] = 1'b1;
      cap_bank_d         = ~cap_bank_q;
    end
    if (drn_fire) begin
      if (at_last) begin
        // Explicit wrap: NUM_ROWS need not be a power of two.
        rd_idx_d           = '0;
        full_d[drn_bank_q] = 1'b0;
        drn_bank_d         = ~drn_bank_q;
      end else begin
        rd_idx_d = rd_idx_q + IDX_W'(1);
      end
    end
  end

  // Control state with synchronous reset; a reset discards any pending set.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= 2'b00;
      cap_bank_q <= 1'b0;
      drn_bank_q <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      full_q     <= full_d;
      cap_bank_q <= cap_bank_d;
      drn_bank_q <= drn_bank_d;
      rd_idx_q   <= rd_idx_d;
    end
  end

  // Write every row of the selected bank in one cycle on an accepted capture.
  always_ff @(posedge clk) begin
    if (cap_fire) begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        if (cap_bank_q) begin
          bank1_q[i] <= capture_data_i[i];
        end else begin
          bank0_q[i] <= capture_data_i[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_osram_drain.sv
// Bench for osram_drain: directed scenarios plus random traffic against a set-queue reference model.
// Inputs change 1ns after the rising edge; the predictor and monitors sample on the falling edge.
// A 3-row instance covers the non-power-of-two index wrap.
module tb_osram_drain;

  localparam int N  = 4;
  localparam int N3 = 3;
  localparam int W  = 16;

  typedef struct packed {
    logic [W-1:0] dat;
    logic [1:0]   idx;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main 4-row instance
  logic         cap_vld, cap_rdy, drain_valid, drn_rdy, drain_last;
  logic [W-1:0] cap_dat [N];
  logic [W-1:0] drain_data;
  logic [1:0]   drain_idx;
  logic [1:0]   bank_full;

  // 3-row instance
  logic         cap3_vld, cap3_rdy, drain3_valid, drn3_rdy, drain3_last;
  logic [W-1:0] cap3_dat [N3];
  logic [W-1:0] drain3_data;
  logic [1:0]   drain3_idx;
  logic [1:0]   bank3_full;

  osram_drain #(.NUM_ROWS(N), .ROW_W(W)) dut (
    .clk(clk), .rst(rst),
    .capture_valid_i(cap_vld), .capture_ready_o(cap_rdy), .capture_data_i(cap_dat),
    .drain_valid_o(drain_valid), .drain_ready_i(drn_rdy), .drain_data_o(drain_data),
    .drain_idx_o(drain_idx), .drain_last_o(drain_last), .bank_full_o(bank_full)
  );

  osram_drain #(.NUM_ROWS(N3), .ROW_W(W)) dut3 (
    .clk(clk), .rst(rst),
    .capture_valid_i(cap3_vld), .capture_ready_o(cap3_rdy), .capture_data_i(cap3_dat),
    .drain_valid_o(drain3_valid), .drain_ready_i(drn3_rdy), .drain_data_o(drain3_data),
    .drain_idx_o(drain3_idx), .drain_last_o(drain3_last), .bank_full_o(bank3_full)
  );

  beat_t exp_q[$];
  beat_t exp3_q[$];
  int    checks = 0;
  int    errors = 0;
  int    model_rows = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: actual beat %0h with nothing expected", name, act);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) cap_dat[i] = base + W'(i);
  endtask

  // Reference model: the buffer is a queue of at most two sets; a capture is
  // taken whenever fewer than two sets (full or partial) are still pending.
  always @(negedge clk) begin
    int  held;
    bit  rdy_e;
    bit  vld_e;
    if (rst) begin
      exp_q.delete();
      model_rows = 0;
    end else begin
      held  = (model_rows + N - 1) / N;
      rdy_e = (held < 2);
      vld_e = (model_rows > 0);
      check("capture_ready", cap_rdy, rdy_e);
      check("drain_valid", drain_valid, vld_e);
      check("bank_full_count", $countones(bank_full), held);
      if (cap_vld && rdy_e) begin
        for (int i = 0; i < N; i++) exp_q.push_back('{cap_dat[i], 2'(i), (i == N - 1)});
        model_rows += N;
      end
      if (vld_e && drn_rdy) model_rows -= 1;
    end
  end

  // Monitor for the 4-row instance: pops on each beat, checks hold under stall.
  logic         stall_seen = 1'b0;
  logic [W-1:0] stall_dat;
  logic [1:0]   stall_idx;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen && drain_valid) begin
        check("stall_data", drain_data, stall_dat);
        check("stall_idx", drain_idx, stall_idx);
      end
      if (drain_valid && drn_rdy) begin
        if (exp_q.size() == 0) begin
          unexpected("extra_beat", drain_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", drain_data, e.dat);
          check("beat_idx", drain_idx, e.idx);
          check("beat_last", drain_last, e.last);
        end
      end
      stall_seen = drain_valid && !drn_rdy;
      stall_dat  = drain_data;
      stall_idx  = drain_idx;
    end
  end

  // Monitor for the 3-row instance.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && drain3_valid && drn3_rdy) begin
      if (exp3_q.size() == 0) begin
        unexpected("n3_extra_beat", drain3_data);
      end else begin
        e = exp3_q.pop_front();
        check("n3_beat_data", drain3_data, e.dat);
        check("n3_beat_idx", drain3_idx, e.idx);
        check("n3_beat_last", drain3_last, e.last);
      end
    end
  end

  task automatic wait_drain(input int lim, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      step();
      n++;
    end
    check("drain_complete", exp_q.size(), 0);
    check("drain_idle", drain_valid, 0);
  endtask

  initial begin
    int n;
    logic pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    cap_vld = 0; drn_rdy = 0; load('0);
    cap3_vld = 0; drn3_rdy = 0;
    for (int i = 0; i < N3; i++) cap3_dat[i] = '0;

    // Reset state
    rst = 1; repeat (2) step(); rst = 0;
    check("rst_capture_ready", cap_rdy, 1);
    check("rst_drain_valid", drain_valid, 0);
    check("rst_drain_idx", drain_idx, 0);
    check("rst_drain_last", drain_last, 0);
    check("rst_bank_full", bank_full, 2'b00);

    // Single set, drain_ready held high
    load(16'h1000); cap_vld = 1; drn_rdy = 1; step(); cap_vld = 0;
    check("t1_valid_rise", drain_valid, 1);
    wait_drain(20, n);
    check("t1_beat_cycles", n, 4);
    check("t1_bank_full", bank_full, 2'b00);

    // Two sets fill both banks, a third is ignored
    drn_rdy = 0;
    load(16'h00A0); cap_vld = 1; step();
    load(16'h00B0); step(); cap_vld = 0;
    check("t2_bank_full", bank_full, 2'b11);
    check("t2_capture_ready", cap_rdy, 0);
    load(16'h00C0); cap_vld = 1; step(); cap_vld = 0;
    check("t2_still_full", bank_full, 2'b11);
    drn_rdy = 1;
    wait_drain(20, n);
    check("t2_beat_cycles", n, 8);

    // Backpressure pattern
    drn_rdy = 0;
    load(16'h0D00); cap_vld = 1; step(); cap_vld = 0;
    for (int i = 0; i < 7; i++) begin
      drn_rdy = pat[i];
      step();
    end
    check("t3_all_drained", exp_q.size(), 0);
    check("t3_valid_low", drain_valid, 0);
    check("t3_bank_full", bank_full, 2'b00);

    // Capture held while the last row of bank0 drains
    drn_rdy = 0;
    load(16'h0E00); cap_vld = 1; step();
    load(16'h0F00); step(); cap_vld = 0;
    drn_rdy = 1; repeat (3) step();
    load(16'h0700); cap_vld = 1;
    check("t4_refuse_ready", cap_rdy, 0);
    step();
    check("t4_accept_ready", cap_rdy, 1);
    step(); cap_vld = 0;
    check("t4_bank_full", bank_full, 2'b11);
    wait_drain(20, n);
    check("t4_beat_cycles", n, 7);

    // Reset in the middle of a drain
    drn_rdy = 0;
    load(16'h0100); cap_vld = 1; step();
    load(16'h0200); step(); cap_vld = 0;
    drn_rdy = 1; repeat (2) step(); drn_rdy = 0;
    check("t5_pre_full", bank_full, 2'b11);
    rst = 1; step(); rst = 0;
    check("t5_drain_valid", drain_valid, 0);
    check("t5_capture_ready", cap_rdy, 1);
    check("t5_bank_full", bank_full, 2'b00);
    check("t5_drain_idx", drain_idx, 0);
    check("t5_drain_last", drain_last, 0);
    load(16'h0300); cap_vld = 1; step(); cap_vld = 0;
    check("t5_bank0_full", bank_full, 2'b01);
    drn_rdy = 1;
    wait_drain(20, n);
    check("t5_beat_cycles", n, 4);

    // Three-row instance: two sets drained back to back
    drn3_rdy = 1;
    check("n3_ready_a", cap3_rdy, 1);
    for (int i = 0; i < N3; i++) begin
      cap3_dat[i] = 16'h3000 + W'(i);
      exp3_q.push_back('{cap3_dat[i], 2'(i), (i == N3 - 1)});
    end
    cap3_vld = 1; step();
    check("n3_ready_b", cap3_rdy, 1);
    for (int i = 0; i < N3; i++) begin
      cap3_dat[i] = 16'h3100 + W'(i);
      exp3_q.push_back('{cap3_dat[i], 2'(i), (i == N3 - 1)});
    end
    step(); cap3_vld = 0;
    n = 0;
    while (exp3_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("n3_all_drained", exp3_q.size(), 0);
    check("n3_beat_cycles", n, 5);
    check("n3_valid_low", drain3_valid, 0);
    check("n3_bank_full", bank3_full, 2'b00);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      cap_vld = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < N; i++) cap_dat[i] = W'($urandom);
      drn_rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    cap_vld = 0; drn_rdy = 1;
    wait_drain(40, n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
